// File: rtl/imem_responder.sv
// Instruction-memory responder: word-addressed array behind the fetch-stage
// imem_addr/imem_rmask interface, answering every request after LATENCY cycles.
module imem_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h1eceb000,
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned LATENCY   = 1,
    parameter logic [31:0] FILL_WORD = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] imem_addr,
    input  logic [3:0]  imem_rmask,
    output logic [31:0] imem_rdata,
    output logic        imem_resp,
    output logic        imem_err,
    input  logic        prog_we,
    input  logic [31:0] prog_addr,
    input  logic [31:0] prog_wdata,
    output logic [31:0] resp_count
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic        valid;
        logic        err;
        logic [31:0] data;
    } stage_t;

    logic [31:0]   mem [DEPTH];

    logic [29:0]   rd_woff;
    logic [29:0]   wr_woff;
    logic          rd_in_range;
    logic          rd_misaligned;
    logic          wr_ok;
    logic [AW-1:0] rd_idx;
    logic [AW-1:0] wr_idx;
    logic [31:0]   rd_word;
    logic [31:0]   lane_mask;
    stage_t        req_stage;
    stage_t        pipe [LATENCY];

    // NOTE: always_comb uses blocking assignments and gives every output a
    // value on every path, so no latch is inferred; always_ff uses <= only.
    always_comb begin
        rd_woff       = 30'((imem_addr - BASE_ADDR) >> 2);
        rd_in_range   = (imem_addr >= BASE_ADDR) && (rd_woff < 30'(DEPTH));
        rd_misaligned = (imem_addr[1:0] != 2'b00);
        rd_idx        = rd_woff[AW-1:0];
        rd_word       = rd_in_range ? mem[rd_idx] : FILL_WORD;
        lane_mask     = {{8{imem_rmask[3]}}, {8{imem_rmask[2]}},
                         {8{imem_rmask[1]}}, {8{imem_rmask[0]}}};

        // Idle stages carry zeros so the outputs read 0 between responses.
        req_stage.valid = (imem_rmask != 4'h0);
        req_stage.err   = req_stage.valid && (rd_misaligned || !rd_in_range);
        req_stage.data  = req_stage.valid ? (rd_word & lane_mask) : 32'h0;
    end

    always_comb begin
        wr_woff = 30'((prog_addr - BASE_ADDR) >> 2);
        wr_idx  = wr_woff[AW-1:0];
        wr_ok   = (prog_addr >= BASE_ADDR) && (wr_woff < 30'(DEPTH))
                  && (prog_addr[1:0] == 2'b00);
    end

    // NOTE: the storage array has no reset: program contents survive rst, and
    // a reset term would prevent mapping onto RAM macros.
    // The read above sees the pre-edge contents, giving read-before-write.
    always_ff @(posedge clk) begin
        if (prog_we && wr_ok) begin
            mem[wr_idx] <= prog_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(LATENCY); i++) begin
                pipe[i] <= '0;
            end
            resp_count <= 32'h0;
        end else begin
            pipe[0] <= req_stage;
            for (int i = 1; i < int'(LATENCY); i++) begin
                pipe[i] <= pipe[i-1];
            end
            if (pipe[LATENCY-1].valid) begin
                resp_count <= resp_count + 32'd1;
            end
        end
    end

    assign imem_resp  = pipe[LATENCY-1].valid;
    assign imem_err   = pipe[LATENCY-1].err;
    assign imem_rdata = pipe[LATENCY-1].data;

endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder: two instances (LATENCY 1 and 3)
// share stimulus and are compared against a cycle-indexed response model.
module tb_imem_responder;

    localparam logic [31:0] BASE  = 32'h1eceb000;
    localparam int          DEPTH = 64;
    localparam logic [31:0] FILL  = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic [3:0]  imem_rmask;
    logic        prog_we;
    logic [31:0] prog_addr;
    logic [31:0] prog_wdata;

    logic [31:0] rdata1, rdata3, count1, count3;
    logic        resp1, resp3, err1, err3;

    int checks   = 0;
    int failures = 0;

    // Reference model: storage, responses keyed by the cycle they must appear in.
    logic [31:0] ref_mem [DEPTH];
    logic [32:0] exp1 [int];
    logic [32:0] exp3 [int];
    int          cyc = 0;
    logic [31:0] mcnt1, mcnt3;
    logic        e1_v, e3_v, e1_e, e3_e;
    logic [31:0] e1_d, e3_d;

    imem_responder #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .LATENCY(1), .FILL_WORD(FILL)) u_dut1 (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rmask(imem_rmask),
        .imem_rdata(rdata1), .imem_resp(resp1), .imem_err(err1),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata),
        .resp_count(count1));

    imem_responder #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .LATENCY(3), .FILL_WORD(FILL)) u_dut3 (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rmask(imem_rmask),
        .imem_rdata(rdata3), .imem_resp(resp3), .imem_err(err3),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata),
        .resp_count(count3));

    always #5 clk = ~clk;

    function automatic logic [32:0] model_read(input logic [31:0] addr, input logic [3:0] mask);
        longint      off;
        logic [31:0] w;
        logic        bad;
        off = longint'(addr) - longint'(BASE);
        if (off >= 0 && off / 4 < DEPTH) begin
            w   = ref_mem[int'(off / 4)];
            bad = (addr % 4 != 0);
        end else begin
            w   = FILL;
            bad = 1'b1;
        end
        for (int b = 0; b < 4; b++) begin
            if (!mask[b]) w[8*b +: 8] = 8'h00;
        end
        return {bad, w};
    endfunction

    // One clock: drive inputs, advance the model, then look just after the edge.
    task automatic tick(input logic [31:0] a, input logic [3:0] m,
                        input logic we, input logic [31:0] pa, input logic [31:0] pd);
        longint poff;
        imem_addr  = a;
        imem_rmask = m;
        prog_we    = we;
        prog_addr  = pa;
        prog_wdata = pd;
        if (m != 4'h0) begin
            exp1[cyc + 1] = model_read(a, m);
            exp3[cyc + 3] = model_read(a, m);
        end
        poff = longint'(pa) - longint'(BASE);
        if (we && poff >= 0 && poff % 4 == 0 && poff / 4 < DEPTH) begin
            ref_mem[int'(poff / 4)] = pd;
        end
        @(posedge clk);
        cyc++;
        #1;
        e1_v = exp1.exists(cyc);
        {e1_e, e1_d} = e1_v ? exp1[cyc] : 33'h0;
        exp1.delete(cyc);
        e3_v = exp3.exists(cyc);
        {e3_e, e3_d} = e3_v ? exp3[cyc] : 33'h0;
        exp3.delete(cyc);
    endtask

    // resp_count reflects responses shown before the current cycle.
    task automatic count_shown;
        if (e1_v) mcnt1 = mcnt1 + 32'd1;
        if (e3_v) mcnt3 = mcnt3 + 32'd1;
    endtask

    task automatic idle;
        tick(32'h0, 4'h0, 1'b0, 32'h0, 32'h0);
        count_shown();
    endtask

    task automatic test_reset;
        rst = 1'b0;
        imem_addr = '0; imem_rmask = '0; prog_we = 1'b0; prog_addr = '0; prog_wdata = '0;
        mcnt1 = '0; mcnt3 = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({resp1, err1, rdata1, count1} !== 66'h0) begin
            failures++;
            $display("FAIL reset_l1 resp=%b err=%b rdata=%h cnt=%h expected all zero", resp1, err1, rdata1, count1);
        end
        checks++;
        if ({resp3, err3, rdata3, count3} !== 66'h0) begin
            failures++;
            $display("FAIL reset_l3 resp=%b err=%b rdata=%h cnt=%h expected all zero", resp3, err3, rdata3, count3);
        end
        #2 rst = 1'b1;
    endtask

    task automatic test_preload;
        for (int i = 0; i < DEPTH; i++) begin
            tick(32'h0, 4'h0, 1'b1, BASE + 32'(4 * i), $urandom);
            count_shown();
        end
        tick(32'h0, 4'h0, 1'b1, BASE, 32'h00500093);
        count_shown();
        tick(32'h0, 4'h0, 1'b1, BASE + 32'd4, 32'h00a00113);
        count_shown();
        idle();
    endtask

    task automatic test_basic;
        tick(BASE, 4'hf, 1'b0, 32'h0, 32'h0);
        count_shown();
        checks++;
        if ({resp1, err1, rdata1} !== {1'b1, 1'b0, 32'h00500093}) begin
            failures++;
            $display("FAIL basic_w0 resp=%b err=%b rdata=%h expected 1 0 00500093", resp1, err1, rdata1);
        end
        tick(BASE + 32'd4, 4'hf, 1'b0, 32'h0, 32'h0);
        count_shown();
        checks++;
        if ({resp1, err1, rdata1} !== {1'b1, 1'b0, 32'h00a00113}) begin
            failures++;
            $display("FAIL basic_w1 resp=%b err=%b rdata=%h expected 1 0 00a00113", resp1, err1, rdata1);
        end
        idle();
        checks++;
        if ({resp1, err1, rdata1} !== 34'h0 || count1 !== 32'd2) begin
            failures++;
            $display("FAIL basic_idle resp=%b err=%b rdata=%h cnt=%0d expected 0 0 0 cnt=2", resp1, err1, rdata1, count1);
        end
        repeat (3) idle();
    endtask

    task automatic test_latency3;
        logic exp_v;
        checks++;
        if (resp3 !== 1'b0) begin
            failures++;
            $display("FAIL lat3_cycle_t resp=%b expected 0", resp3);
        end
        for (int k = 0; k < 8; k++) begin
            if (k < 5) tick(BASE + 32'(4 * k), 4'hf, 1'b0, 32'h0, 32'h0);
            else       tick(32'h0, 4'h0, 1'b0, 32'h0, 32'h0);
            count_shown();
            exp_v = (k >= 2 && k <= 6);
            checks++;
            if (resp3 !== exp_v || (exp_v && rdata3 !== ref_mem[k-2]) || (!exp_v && rdata3 !== 32'h0)) begin
                failures++;
                $display("FAIL lat3_step%0d resp=%b rdata=%h expected resp=%b rdata=%h",
                         k, resp3, rdata3, exp_v, exp_v ? ref_mem[k-2] : 32'h0);
            end
        end
    endtask

    task automatic test_range;
        logic [31:0] addrs [3];
        logic [31:0] want  [3];
        addrs = '{32'h1eceaffc, BASE + 32'(4 * DEPTH), BASE + 32'd2};
        want  = '{FILL, FILL, 32'h00500093};
        for (int k = 0; k < 3; k++) begin
            tick(addrs[k], 4'hf, 1'b0, 32'h0, 32'h0);
            count_shown();
            checks++;
            if ({resp1, err1, rdata1} !== {1'b1, 1'b1, want[k]}) begin
                failures++;
                $display("FAIL range_%h resp=%b err=%b rdata=%h expected 1 1 %h", addrs[k], resp1, err1, rdata1, want[k]);
            end
        end
        repeat (3) idle();
    endtask

    task automatic test_mask;
        tick(32'h0, 4'h0, 1'b1, BASE + 32'd12, 32'hdeadbeef);
        count_shown();
        tick(BASE + 32'd12, 4'b0011, 1'b0, 32'h0, 32'h0);
        count_shown();
        checks++;
        if ({resp1, err1, rdata1} !== {1'b1, 1'b0, 32'h0000beef}) begin
            failures++;
            $display("FAIL mask_0011 resp=%b err=%b rdata=%h expected 1 0 0000beef", resp1, err1, rdata1);
        end
        tick(BASE + 32'd12, 4'h0, 1'b0, 32'h0, 32'h0);
        count_shown();
        checks++;
        if ({resp1, err1, rdata1} !== 34'h0) begin
            failures++;
            $display("FAIL mask_zero resp=%b err=%b rdata=%h expected no response", resp1, err1, rdata1);
        end
        repeat (3) idle();
    endtask

    task automatic test_read_before_write;
        tick(32'h0, 4'h0, 1'b1, BASE + 32'd8, 32'h22222222);
        count_shown();
        tick(BASE + 32'd8, 4'hf, 1'b1, BASE + 32'd8, 32'h11111111);
        count_shown();
        checks++;
        if ({resp1, rdata1} !== {1'b1, 32'h22222222}) begin
            failures++;
            $display("FAIL rbw_old resp=%b rdata=%h expected 1 22222222", resp1, rdata1);
        end
        tick(BASE + 32'd8, 4'hf, 1'b0, 32'h0, 32'h0);
        count_shown();
        checks++;
        if ({resp1, rdata1} !== {1'b1, 32'h11111111}) begin
            failures++;
            $display("FAIL rbw_new resp=%b rdata=%h expected 1 11111111", resp1, rdata1);
        end
        repeat (3) idle();
    endtask

    task automatic test_random;
        logic [31:0] a, pa;
        logic [3:0]  m;
        for (int n = 0; n < 400; n++) begin
            a  = ($urandom_range(0, 7) == 0) ? $urandom : BASE - 32'd8 + 32'($urandom_range(0, 4 * DEPTH + 15));
            m  = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
            pa = BASE - 32'd4 + 32'($urandom_range(0, 4 * DEPTH + 7));
            tick(a, m, ($urandom_range(0, 3) == 0), pa, $urandom);
            checks++;
            if ({resp1, err1, rdata1} !== {e1_v, e1_e, e1_d}) begin
                failures++;
                $display("FAIL rand_l1 cyc=%0d resp=%b err=%b rdata=%h expected %b %b %h", cyc, resp1, err1, rdata1, e1_v, e1_e, e1_d);
            end
            checks++;
            if ({resp3, err3, rdata3} !== {e3_v, e3_e, e3_d}) begin
                failures++;
                $display("FAIL rand_l3 cyc=%0d resp=%b err=%b rdata=%h expected %b %b %h", cyc, resp3, err3, rdata3, e3_v, e3_e, e3_d);
            end
            checks++;
            if (count1 !== mcnt1 || count3 !== mcnt3) begin
                failures++;
                $display("FAIL rand_count cyc=%0d cnt1=%0d cnt3=%0d expected %0d %0d", cyc, count1, count3, mcnt1, mcnt3);
            end
            count_shown();
        end
        repeat (4) idle();
    endtask

    task automatic test_reset_midstream;
        tick(BASE, 4'hf, 1'b0, 32'h0, 32'h0);
        count_shown();
        tick(BASE + 32'd4, 4'hf, 1'b0, 32'h0, 32'h0);
        count_shown();
        imem_rmask = 4'h0;
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({resp3, rdata3, count3, resp1, rdata1, count1} !== 130'h0) begin
            failures++;
            $display("FAIL midrst_async resp3=%b rdata3=%h cnt3=%0d resp1=%b rdata1=%h cnt1=%0d expected all zero",
                     resp3, rdata3, count3, resp1, rdata1, count1);
        end
        exp1.delete();
        exp3.delete();
        mcnt1 = '0;
        mcnt3 = '0;
        #1 rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            idle();
            checks++;
            if (resp3 !== 1'b0 || resp1 !== 1'b0) begin
                failures++;
                $display("FAIL midrst_stale step%0d resp3=%b resp1=%b expected 0 0", k, resp3, resp1);
            end
        end
        tick(BASE + 32'd4, 4'hf, 1'b0, 32'h0, 32'h0);
        count_shown();
        for (int k = 1; k <= 3; k++) begin
            if (k > 1) idle();
            checks++;
            if (resp3 !== (k == 3) || (k == 3 && rdata3 !== 32'h00a00113)) begin
                failures++;
                $display("FAIL midrst_first step%0d resp3=%b rdata3=%h expected resp=%b rdata=00a00113", k, resp3, rdata3, (k == 3));
            end
        end
        idle();
        checks++;
        if (count3 !== 32'd1) begin
            failures++;
            $display("FAIL midrst_count cnt3=%0d expected 1", count3);
        end
    endtask

    initial begin
        test_reset();
        test_preload();
        test_basic();
        test_latency3();
        test_range();
        test_mask();
        test_read_before_write();
        test_random();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
